// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports, busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read and busy-clear forwarding.
module regfile_mp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_a,
  input  logic [AW-1:0]       waddr_a,
  input  logic [XLEN-1:0]     wdata_a,
  input  logic                we_b,
  input  logic [AW-1:0]       waddr_b,
  input  logic [XLEN-1:0]     wdata_b,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  output logic [NREG-1:0]     busy_vec
);

  logic [XLEN-1:0] regs_q [NREG] = '{default: '0};
  logic [NREG-1:0] busy_q = '0;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] wsel_a, wsel_b, iss_sel;
  logic [NREG-1:0] busy_view;

  // One-hot selects; entry 0 is never selected so x0 stays zero and never busy.
  always_comb begin
    wsel_a  = '0;
    wsel_b  = '0;
    iss_sel = '0;
    for (int r = 1; r < NREG; r++) begin
      wsel_a[r]  = we_a && (waddr_a == AW'(r));
      wsel_b[r]  = we_b && (waddr_b == AW'(r));
      iss_sel[r] = iss_valid && (iss_rd == AW'(r));
    end
  end

  // A new issue claims the register even if its old producer writes back now.
  assign busy_d = iss_sel | (busy_q & ~(wsel_a | wsel_b));

`ifdef REGFILE_BYPASS_EN
  assign busy_view = busy_q & ~((wsel_a | wsel_b) & ~iss_sel);
`else
  assign busy_view = busy_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int r = 1; r < NREG; r++) begin
        if (wsel_b[r]) begin
          regs_q[r] <= wdata_b;
        end else if (wsel_a[r]) begin
          regs_q[r] <= wdata_a;
        end
      end
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra    = '0;
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = raddr[k*AW +: AW];
      if ((ra != '0) && (32'(ra) < NREG)) begin
        rdata[k*XLEN +: XLEN] = regs_q[ra];
        rbusy[k]              = busy_view[ra];
`ifdef REGFILE_BYPASS_EN
        if (wsel_b[ra]) begin
          rdata[k*XLEN +: XLEN] = wdata_b;
        end else if (wsel_a[ra]) begin
          rdata[k*XLEN +: XLEN] = wdata_a;
        end
`endif
      end
    end
  end

  always_comb begin
    iss_ready = 1'b1;
    if ((iss_rd != '0) && (32'(iss_rd) < NREG)) begin
      iss_ready = ~busy_view[iss_rd];
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                we_a, we_b, iss_valid;
  logic [AW-1:0]       waddr_a, waddr_b, iss_rd;
  logic [XLEN-1:0]     wdata_a, wdata_b;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                iss_ready;
  logic [NREG-1:0]     busy_vec;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .we_a      (we_a),
    .waddr_a   (waddr_a),
    .wdata_a   (wdata_a),
    .we_b      (we_b),
    .waddr_b   (waddr_b),
    .wdata_b   (wdata_b),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .busy_vec  (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we_a = 1'b0; we_b = 1'b0; iss_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; idle();
    waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0; iss_rd = '0; raddr = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    for (int a = 0; a < NREG; a++) begin
      raddr = {5'd0, 5'd0, AW'(a)};
      #1;
      check($sformatf("reset_rdata_x%0d", a), rdata[31:0], 32'h0);
    end
    check("reset_busy_vec", busy_vec, 32'h0);
    iss_rd = 5'd5; #1;
    check("reset_iss_ready", {31'h0, iss_ready}, 32'h1);

    // Writes to x0 on both ports are dropped
    we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hDEADBEEF;
    we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hCAFEF00D;
    tick(); idle();
    raddr = {5'd0, 5'd0, 5'd0}; #1;
    check("x0_after_write", rdata[31:0], 32'h0);

    // Dual write
    we_a = 1'b1; waddr_a = 5'd5; wdata_a = 32'h11111111;
    we_b = 1'b1; waddr_b = 5'd6; wdata_b = 32'h22222222;
    tick(); idle();
    raddr = {5'd5, 5'd6, 5'd0}; #1;
    check("dual_port2_x5", rdata[95:64], 32'h11111111);
    check("dual_port1_x6", rdata[63:32], 32'h22222222);
    check("dual_port0_x0", rdata[31:0], 32'h0);

    // Collision: port B wins
    we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hAAAA0000;
    we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h0000BBBB;
    tick(); idle();
    raddr = {5'd0, 5'd0, 5'd7}; #1;
    check("collision_x7", rdata[31:0], 32'h0000BBBB);

    // Issue x9
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick(); idle();
    raddr = {5'd0, 5'd9, 5'd0}; iss_rd = 5'd9; #1;
    check("issue_busy_vec", busy_vec, 32'h0000_0200);
    check("issue_rbusy_x9", {31'h0, rbusy[1]}, 32'h1);
    check("issue_rbusy_x0", {31'h0, rbusy[0]}, 32'h0);
    check("issue_iss_ready", {31'h0, iss_ready}, 32'h0);

    // Writeback x9 through port A
    we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h00000099; #1;
`ifdef REGFILE_BYPASS_EN
    check("wb_same_cycle_rbusy", {31'h0, rbusy[1]}, 32'h0);
`else
    check("wb_same_cycle_rbusy", {31'h0, rbusy[1]}, 32'h1);
`endif
    tick(); idle(); #1;
    check("wb_busy_vec", busy_vec, 32'h0);
    check("wb_iss_ready", {31'h0, iss_ready}, 32'h1);
    check("wb_rdata_x9", rdata[63:32], 32'h00000099);

    // Issue and writeback in the same cycle: busy stays set
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h00000077; #1;
    check("set_over_clear_ready", {31'h0, iss_ready}, 32'h0);
    tick(); idle(); #1;
    check("set_over_clear_busy", busy_vec, 32'h0000_0200);
    check("set_over_clear_rdata", rdata[63:32], 32'h00000077);
    we_b = 1'b1; waddr_b = 5'd9;
    tick(); idle(); #1;
    check("final_clear_x9", busy_vec, 32'h0);

    // Issue to x0 never sets busy
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick(); idle(); #1;
    check("issue_x0_busy_vec", busy_vec, 32'h0);
    check("issue_x0_ready", {31'h0, iss_ready}, 32'h1);

    // Read-after-write in the same cycle
    we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h12345678;
    raddr = {5'd0, 5'd0, 5'd3}; #1;
`ifdef REGFILE_BYPASS_EN
    check("raw_same_cycle", rdata[31:0], 32'h12345678);
`else
    check("raw_same_cycle", rdata[31:0], 32'h0);
`endif
    tick(); idle(); #1;
    check("raw_next_cycle", rdata[31:0], 32'h12345678);

    // Issue while busy keeps the bit set
    iss_valid = 1'b1; iss_rd = 5'd10;
    tick(); tick(); idle(); #1;
    check("issue_while_busy", busy_vec, 32'h0000_0400);

    // Mid-operation reset
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_rd = 5'd8;
    tick(); idle();
    we_a = 1'b1; waddr_a = 5'd4; wdata_a = 32'h00000055;
    tick(); idle();
    raddr = {5'd0, 5'd0, 5'd4}; #1;
    check("pre_reset_x4", rdata[31:0], 32'h00000055);
    check("pre_reset_busy", busy_vec, 32'h0000_0500);
    rst = 1'b0;
    we_a = 1'b1; waddr_a = 5'd11; wdata_a = 32'h000000FF;
    iss_valid = 1'b1; iss_rd = 5'd12;
    tick(); idle(); rst = 1'b1;
    raddr = {5'd11, 5'd6, 5'd4}; iss_rd = 5'd8; #1;
    check("post_reset_busy", busy_vec, 32'h0);
    check("post_reset_x4", rdata[31:0], 32'h0);
    check("post_reset_x6", rdata[63:32], 32'h0);
    check("post_reset_x11", rdata[95:64], 32'h0);
    check("post_reset_ready", {31'h0, iss_ready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, two-read register file.
- Adds configurable data width, depth and read-port count, plus a second write port.
- Adds a per-register busy scoreboard so a multi-issue/pipelined core can detect RAW/WAW hazards.
- Sits between decode (read, issue) and writeback (two write ports).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; legal range 2..2**AW.
- AW, 5, address width; 2**AW >= NREG.
- NRD, 3, number of read ports (1..8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- we_a  in  1  write-port A enable.
- waddr_a  in  AW  write-port A address.
- wdata_a  in  XLEN  write-port A data.
- we_b  in  1  write-port B enable.
- waddr_b  in  AW  write-port B address.
- wdata_b  in  XLEN  write-port B data.
- raddr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rdata  out  NRD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
- rbusy  out  NRD  per-read-port busy flag of the addressed register.
- iss_valid  in  1  issue request: mark iss_rd busy.
- iss_rd  in  AW  destination register of the issuing instruction.
- iss_ready  out  1  high when iss_rd is not busy, i.e. no WAW hazard.
- busy_vec  out  NREG  full scoreboard state, for debug and stall logic.

Behaviour:
- Reset: while rst=0 at a clk edge, all NREG registers clear to 0 and all busy bits clear. Writes and issues in that cycle are ignored.
- Power-up: registers and busy bits initialise to 0.
- Reset outputs: rdata=0, rbusy=0, busy_vec=0, iss_ready=1 for every address.
- Register 0 is hardwired zero:
  - Writes to address 0 are dropped.
  - Issues to address 0 never set busy.
  - Reads of address 0 return 0 with rbusy=0.
  - iss_ready=1 when iss_rd=0.
- Out-of-range addresses (>= NREG):
  - Reads return 0 with rbusy=0.
  - Writes and issues are ignored.
  - iss_ready=1.
- Write timing: a write takes effect at the clk edge; new data is visible on rdata the cycle after.
- Write collision: we_a and we_b to the same address in the same cycle -> port B wins; the port A data is discarded.
- Reads are combinational (zero latency) from raddr to rdata and rbusy.
- Scoreboard, evaluated per register r at each edge, in this order:
  - Clear: busy[r] clears if we_a or we_b writes r.
  - Set: busy[r] sets if iss_valid=1 and iss_rd=r (r != 0, in range). Set overrides a clear in the same cycle, because the new producer owns r.
  - Issue while busy: if iss_valid=1 while iss_ready=0, the busy bit stays set. The issuing stage is responsible for stalling; this block does not flag an error.
- iss_ready = ~busy[iss_rd], combinational from the registered state. The same-cycle clear is not visible unless bypass is enabled.
- Reset mid-operation: all pending busy bits are dropped and in-flight writes are lost.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled, same-cycle, nonzero, in-range write returns that write's data combinationally. If both ports match, port B data is returned.
  - rbusy and iss_ready treat a same-cycle clearing write as already cleared, unless iss_valid sets that same register in that cycle.
- Undefined:
  - Reads return the pre-edge register contents and busy state.
  - A read-after-write needs one extra cycle.

Test Plan:
- Reset and zero: rst=0 for 2 cycles, then read all addresses -> rdata=0, busy_vec=0. Write 0xDEADBEEF to x0 -> x0 still reads 0.
- Dual write: same cycle, port A writes x5=0x11111111 and port B writes x6=0x22222222. Next cycle raddr={x5,x6,x0} -> rdata={0x11111111,0x22222222,0}.
- Collision: same cycle, A writes x7=0xAAAA0000 and B writes x7=0x0000BBBB -> x7 reads 0x0000BBBB.
- Scoreboard, issue then writeback:
  - Issue x9 -> busy_vec[9]=1, rbusy=1 on a port reading x9, iss_ready=0 for iss_rd=9.
  - Port A writes x9 -> busy clears the next cycle.
  - Same cycle issue x9 plus write x9 -> busy stays 1.
- Bypass: write x3=0x12345678 while reading x3 in the same cycle:
  - With REGFILE_BYPASS_EN: rdata=0x12345678 that cycle.
  - Without: rdata holds the old value that cycle and shows 0x12345678 one cycle later.
- Mid-operation reset: issue x4 and x8, write x4=0x55, then assert rst=0 for 1 cycle -> busy_vec=0, x4 reads 0.
